sap_datapath: RTL and testbench
===============================

Name: sap_datapath

Overview:
SAP-1 datapath that executes the 12-bit control word produced by the microcoded controller.
- Contains the program counter, MAR, 16x8 RAM, instruction register, accumulator, B register, adder/subtractor and output register, all around a shared W bus.
- Feeds the current opcode (IR high nibble) back upstream to the controller.
- Includes a RAM program-load port for the bench or boot logic.

Parameters:
DATA_W, 8, bus/RAM/register width
ADDR_W, 4, address width; RAM depth = 2**ADDR_W; PC and MAR width
OPC_W, 4, opcode width; ADDR_W + OPC_W must equal DATA_W

Ports:
clk  input  1  system clock, rising edge
clr  input  1  asynchronous active-high reset
control_signals  input  12  control word {Cp,Ep,Lm_,CE_,Li_,Ei_,La_,Ea,Su,Eu,Lb_,Lo_}, bit 11..0
opcode  output  OPC_W  ir[7:4], to controller
prog_we  input  1  RAM write enable (load port)
prog_addr  input  ADDR_W  RAM write address
prog_data  input  DATA_W  RAM write data
out_q  output  DATA_W  output register
acc_q  output  DATA_W  accumulator (debug)
pc_q  output  ADDR_W  program counter (debug)
w_bus  output  DATA_W  current bus value (debug)
alu_carry  output  1  combinational ALU carry/no-borrow
bus_conflict  output  1  sticky multiple-driver flag

Behaviour:
- Single clock, one control word per cycle. All register updates occur at the rising edge of clk and use the bus value computed combinationally in that cycle.
- Reset (clr=1, asynchronous, any time including mid-instruction): pc, mar, ir, acc, b, out all go to 0, and bus_conflict goes to 0. RAM contents are not reset.
- Bus drivers (active sense per bit):
  - Ep=1: {0, pc}
  - CE_=0: ram[mar]
  - Ei_=0: {0, ir[3:0]}
  - Ea=1: acc
  - Eu=1: alu result
  - No driver active: w_bus = 0.
- Multiple drivers: w_bus takes the highest-priority driver, in the order Ep > CE > Ei > Ea > Eu. bus_conflict is set at the next edge and held until reset.
- Loads:
  - Lm_=0: mar <= bus[ADDR_W-1:0]
  - Li_=0: ir <= bus
  - La_=0: acc <= bus
  - Lb_=0: b <= bus
  - Lo_=0: out <= bus
  - Several loads in the same cycle are all legal. Example: 0x863 loads MAR and IR from RAM while PC increments.
- Cp=1: pc <= pc+1, wrapping from 15 to 0. The bus value reflects the pre-increment pc.
- ALU (combinational):
  - Su=0: result = acc + b, modulo 2**DATA_W; alu_carry = bit DATA_W of the sum.
  - Su=1: result = acc + ~b + 1; alu_carry = 1 when acc >= b (no borrow).
- Accumulator self-load: La_=0 with Eu=1 makes acc take the ALU result formed from the old acc. There is no combinational loop because acc is registered.
- RAM:
  - Asynchronous read at mar.
  - Synchronous write when prog_we=1.
  - Write to the currently read address in the same cycle: the bus sees the old data; the new data is visible next cycle.
  - prog_we is honoured regardless of control_signals.
- Idle word 0x3E3 (no drivers, no loads, no Cp) leaves all state unchanged.
- Controller HLT state with control_signals held: the datapath simply repeats the held word. No internal halt logic.
- opcode is combinational from ir, so it is valid the cycle after Li_ asserts.

Test Plan:
- Reset: assert clr mid-cycle after arbitrary words -> all registers immediately 0, opcode=0, bus_conflict=0. RAM retains contents.
- Program execution:
  - RAM: 0:0x09, 1:0x1A, 2:0x2B, 3:0xE0, 4:0xF0, 9:0x10, A:0x14, B:0x18.
  - Apply the controller microcode sequence (T1 0x5E3, T2 0x863, T3 0x3E3, then per-opcode words).
  - Expected: acc=0x10, then 0x24, then 0x0C; out_q=0x0C; opcode=0xF at end; pc_q=5.
- ALU wrap: acc=0xF0, b=0x20, word 0x3C7 -> acc=0x10, alu_carry=1. Then acc=0x05, b=0x07, word 0x3CF -> acc=0xFE, alu_carry=0.
- PC wrap: 17 consecutive words with only Cp=1 (0xBE3) -> pc_q sequence 1..15, 0, 1. No other register changes.
- Conflict: pc=3, mar points at 0x55, word with Ep=1 and CE_=0 (0x4E3 & ~0x100 = 0x4E3 with bit 8 cleared) -> w_bus=0x03 and bus_conflict=1 from next edge. The flag stays 1 under idle words until clr.
- RAM write/read collision: mar=6, ram[6]=0x11, prog_we=1 with prog_addr=6 and prog_data=0x99, plus word 0x2C3 -> acc=0x11. Repeating 0x2C3 next cycle -> acc=0x99.

Source files
------------

// File: rtl/sap_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, accumulator, B, adder/subtractor and output
// register around a shared W bus, driven one 12-bit control word per clock.
module sap_datapath #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int OPC_W  = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [11:0]       control_signals,
    output logic [OPC_W-1:0]  opcode,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_q,
    output logic [DATA_W-1:0] acc_q,
    output logic [ADDR_W-1:0] pc_q,
    output logic [DATA_W-1:0] w_bus,
    output logic              alu_carry,
    output logic              bus_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n;
    assign {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, ea, su, eu, lb_n, lo_n} = control_signals;

    logic [ADDR_W-1:0] pc_d, mar_q, mar_d;
    logic [DATA_W-1:0] ir_q, ir_d, b_q, b_d, acc_d, out_d;
    logic              bus_conflict_q, bus_conflict_d;

    logic [DATA_W-1:0] ram_q [DEPTH];
    logic [DATA_W-1:0] ram_rd;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W:0]   alu_sum;
    logic [4:0]        drv;
    logic              multi_drv;

    assign ram_rd = ram_q[mar_q];

    // Subtraction is acc + ~b + 1, so the carry out doubles as "no borrow".
    assign alu_sum   = {1'b0, acc_q} + {1'b0, (su ? ~b_q : b_q)} + {{DATA_W{1'b0}}, su};
    assign alu_res   = alu_sum[DATA_W-1:0];
    assign alu_carry = alu_sum[DATA_W];

    assign drv       = {ep, ~ce_n, ~ei_n, ea, eu};
    assign multi_drv = |(drv & (drv - 5'd1));

    assign opcode       = ir_q[DATA_W-1 -: OPC_W];
    assign bus_conflict = bus_conflict_q;

    // Priority mux: Ep > CE > Ei > Ea > Eu; an undriven bus reads as zero.
    always_comb begin
        w_bus = '0;
        if (ep)
            w_bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
        else if (!ce_n)
            w_bus = ram_rd;
        else if (!ei_n)
            w_bus = {{(DATA_W-ADDR_W){1'b0}}, ir_q[ADDR_W-1:0]};
        else if (ea)
            w_bus = acc_q;
        else if (eu)
            w_bus = alu_res;
    end

    always_comb begin
        pc_d           = cp    ? pc_q + ADDR_W'(1)    : pc_q;
        mar_d          = !lm_n ? w_bus[ADDR_W-1:0]    : mar_q;
        ir_d           = !li_n ? w_bus                : ir_q;
        acc_d          = !la_n ? w_bus                : acc_q;
        b_d            = !lb_n ? w_bus                : b_q;
        out_d          = !lo_n ? w_bus                : out_q;
        bus_conflict_d = bus_conflict_q | multi_drv;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q           <= '0;
            mar_q          <= '0;
            ir_q           <= '0;
            acc_q          <= '0;
            b_q            <= '0;
            out_q          <= '0;
            bus_conflict_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            mar_q          <= mar_d;
            ir_q           <= ir_d;
            acc_q          <= acc_d;
            b_q            <= b_d;
            out_q          <= out_d;
            bus_conflict_q <= bus_conflict_d;
        end
    end

    // Program memory keeps its contents across clr; the load port has no gating.
    always_ff @(posedge clk) begin
        if (prog_we)
            ram_q[prog_addr] <= prog_data;
    end

endmodule

// File: tb/tb_sap_datapath.sv
// Directed bench for sap_datapath: expectations are queued by the driver and popped
// by a negedge monitor that compares them against the live DUT outputs.
module tb_sap_datapath;

    localparam logic [11:0] IDLE = 12'h3E3;

    localparam int S_ACC   = 0;
    localparam int S_OUT   = 1;
    localparam int S_PC    = 2;
    localparam int S_OPC   = 3;
    localparam int S_BUS   = 4;
    localparam int S_CARRY = 5;
    localparam int S_CONF  = 6;

    logic        clk = 1'b0;
    logic        clr;
    logic [11:0] ctrl;
    logic [3:0]  opcode;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [7:0]  out_q, acc_q, w_bus;
    logic [3:0]  pc_q;
    logic        alu_carry, bus_conflict;

    sap_datapath #(.DATA_W(8), .ADDR_W(4), .OPC_W(4)) dut (
        .clk(clk), .clr(clr), .control_signals(ctrl), .opcode(opcode),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .out_q(out_q), .acc_q(acc_q), .pc_q(pc_q), .w_bus(w_bus),
        .alu_carry(alu_carry), .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         sig_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic expect_sig(input int sig, input logic [7:0] val, input string name);
        exp_q.push_back(val);
        sig_q.push_back(sig);
        name_q.push_back(name);
    endtask

    function automatic logic [7:0] actual(input int sig);
        case (sig)
            S_ACC:   return acc_q;
            S_OUT:   return out_q;
            S_PC:    return {4'b0, pc_q};
            S_OPC:   return {4'b0, opcode};
            S_BUS:   return w_bus;
            S_CARRY: return {7'b0, alu_carry};
            S_CONF:  return {7'b0, bus_conflict};
            default: return 8'hxx;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        logic [7:0] e, a;
        int         s;
        string      n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            s = sig_q.pop_front();
            n = name_q.pop_front();
            a = actual(s);
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got %02h expected %02h (t=%0t)", n, a, e, $time);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [11:0] w);
        ctrl = w;
        tick();
    endtask

    task automatic step_prog(input logic [11:0] w, input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step(w);
        prog_we   = 1'b0;
    endtask

    // Let pending checks drain, then raise clr mid-cycle and check before the next edge.
    task automatic apply_clr(input string tag);
        @(negedge clk);
        @(posedge clk);
        #3;
        clr = 1'b1;
        expect_sig(S_ACC,  8'h00, {tag, "_acc"});
        expect_sig(S_OUT,  8'h00, {tag, "_out"});
        expect_sig(S_PC,   8'h00, {tag, "_pc"});
        expect_sig(S_OPC,  8'h00, {tag, "_opcode"});
        expect_sig(S_CONF, 8'h00, {tag, "_conflict"});
        tick();
        clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [3:0]  pa [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hB};
    logic [7:0]  pd [8] = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h10, 8'h14, 8'h18};
    logic [11:0] t4 [5] = '{12'h1A3, 12'h1A3, 12'h1A3, 12'h3F2, 12'h3E3};
    logic [11:0] t5 [5] = '{12'h2C3, 12'h2E1, 12'h2E1, 12'h3E3, 12'h3E3};
    logic [11:0] t6 [5] = '{12'h3E3, 12'h3C7, 12'h3CF, 12'h3E3, 12'h3E3};
    logic [7:0]  ex_acc [5] = '{8'h10, 8'h24, 8'h0C, 8'h0C, 8'h0C};
    logic [7:0]  ex_out [5] = '{8'h00, 8'h00, 8'h00, 8'h0C, 8'h0C};
    logic [7:0]  ex_opc [5] = '{8'h00, 8'h01, 8'h02, 8'h0E, 8'h0F};

    initial begin
        clr       = 1'b1;
        ctrl      = IDLE;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;

        for (int i = 0; i < 8; i++) step_prog(IDLE, pa[i], pd[i]);

        expect_sig(S_ACC,  8'h00, "rst_acc");
        expect_sig(S_OUT,  8'h00, "rst_out");
        expect_sig(S_PC,   8'h00, "rst_pc");
        expect_sig(S_OPC,  8'h00, "rst_opcode");
        expect_sig(S_CONF, 8'h00, "rst_conflict");
        expect_sig(S_BUS,  8'h00, "rst_bus_idle");
        step(IDLE);

        // Program: LDA 9, ADD A, SUB B, OUT, HLT
        for (int i = 0; i < 5; i++) begin
            ctrl = 12'h5E3;
            expect_sig(S_BUS, 8'(i), "t1_bus_pc");
            tick();
            ctrl = 12'h863;
            expect_sig(S_BUS, pd[i], "t2_bus_ram");
            tick();
            expect_sig(S_PC,  8'(i + 1), "fetch_pc");
            expect_sig(S_OPC, ex_opc[i], "fetch_opcode");
            step(IDLE);
            step(t4[i]);
            step(t5[i]);
            step(t6[i]);
            expect_sig(S_ACC, ex_acc[i], "prog_acc");
            expect_sig(S_OUT, ex_out[i], "prog_out");
        end
        expect_sig(S_CONF, 8'h00, "prog_no_conflict");
        step(IDLE);

        // Arbitrary words, then asynchronous clear mid-cycle
        step(12'h863);
        step(12'h2C3);
        ctrl = 12'h863;
        apply_clr("clr1");
        ctrl = IDLE;

        // RAM survives clear: mar=0 reads 0x09
        step(12'h2C3);
        expect_sig(S_ACC, 8'h09, "ram_retained");

        // PC wrap with Cp only
        for (int i = 1; i <= 17; i++) begin
            step(12'hBE3);
            expect_sig(S_PC, 8'(i % 16), "pc_wrap");
        end
        expect_sig(S_ACC, 8'h09, "pcwrap_acc_hold");
        expect_sig(S_OUT, 8'h00, "pcwrap_out_hold");
        expect_sig(S_OPC, 8'h00, "pcwrap_opc_hold");
        step(IDLE);

        // ALU add with carry out: 0xF0 + 0x20
        step_prog(IDLE, 4'h0, 8'hF0);
        step_prog(12'h2C3, 4'h0, 8'h20);
        expect_sig(S_ACC, 8'hF0, "alu_load_acc");
        step(12'h2E1);
        ctrl = 12'h3C7;
        expect_sig(S_CARRY, 8'h01, "add_carry");
        expect_sig(S_BUS,   8'h10, "add_bus");
        tick();
        expect_sig(S_ACC, 8'h10, "add_wrap_acc");
        step(IDLE);

        // ALU subtract with borrow: 0x05 - 0x07
        step_prog(IDLE, 4'h0, 8'h05);
        step_prog(12'h2C3, 4'h0, 8'h07);
        step(12'h2E1);
        ctrl = 12'h3CF;
        expect_sig(S_CARRY, 8'h00, "sub_borrow_carry");
        expect_sig(S_BUS,   8'hFE, "sub_bus");
        tick();
        expect_sig(S_ACC, 8'hFE, "sub_acc");
        step(IDLE);

        // RAM write/read collision at mar=6
        step_prog(IDLE, 4'h6, 8'h11);
        step_prog(IDLE, 4'h0, 8'h06);
        step(12'h263);
        expect_sig(S_OPC, 8'h00, "ir_load_opc");
        ctrl = 12'h1A3;
        expect_sig(S_BUS, 8'h06, "ir_operand_bus");
        tick();
        step_prog(12'h2C3, 4'h6, 8'h99);
        expect_sig(S_ACC, 8'h11, "collide_old");
        step(12'h2C3);
        expect_sig(S_ACC, 8'h99, "collide_new");
        ctrl = IDLE;

        // Bus conflict: Ep and CE together with pc=3, ram[mar]=0x55
        apply_clr("clr2");
        step_prog(IDLE, 4'h0, 8'h55);
        repeat (3) step(12'hBE3);
        ctrl = 12'h4E3;
        expect_sig(S_BUS,  8'h03, "conflict_bus");
        expect_sig(S_CONF, 8'h00, "conflict_before");
        tick();
        expect_sig(S_CONF, 8'h01, "conflict_set");
        expect_sig(S_PC,   8'h03, "conflict_pc");
        for (int i = 0; i < 3; i++) begin
            step(IDLE);
            expect_sig(S_CONF, 8'h01, "conflict_sticky");
        end
        step(IDLE);
        apply_clr("clr3");
        step(IDLE);
        expect_sig(S_CONF, 8'h00, "conflict_after_clr");

        // Drain remaining expectations within a bounded number of cycles
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
            errors += exp_q.size();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
